// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID check controller.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_CHECK
  } sysid_state_t;

  // Word index on the system-ID slave
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Bit positions when the status flags are mirrored into a CSR
  localparam int STAT_ID_OK   = 0;
  localparam int STAT_TS_OK   = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_BUSY    = 3;

endpackage

// File: rtl/sysid_rd_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module sysid_rd_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clock) begin
    if (!reset_n)               count <= '0;
    else if (load)              count <= load_val;
    else if (dec && count != 0) count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master: fetches sysid ID/timestamp words, compares them
// against build-time values and reports match / mismatch / timeout.
module sysid_check_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID      = 32'd8,
  parameter logic [31:0] EXP_TS      = 32'd1649580841,
  parameter int          TIMEOUT_CYC = 256,
  parameter int          RECHECK_CYC = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Timers expire at zero, so load N-1 to get N cycles of run time
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYC - 1);
  localparam logic [31:0] RC_LOAD = 32'((RECHECK_CYC > 0) ? RECHECK_CYC - 1 : 0);
  localparam bit          RC_EN   = (RECHECK_CYC > 0);

  sysid_state_t state;

  logic in_req, in_wait, rd_done;
  logic to_load, to_exp, abort;
  logic rc_load, rc_exp, rc_fire, rc_arm, go;

  assign in_req  = (state == ST_ID_REQ)  || (state == ST_TS_REQ);
  assign in_wait = (state == ST_ID_WAIT) || (state == ST_TS_WAIT);
  assign rd_done = in_wait && avm_readdatavalid;

  // A read that completes on the expiry edge still counts as completed
  assign abort   = to_exp && (in_req || (in_wait && !avm_readdatavalid));

  // Recheck only arms after a sequence has ended, never straight out of reset
  assign rc_fire = RC_EN && rc_arm && rc_exp && (state == ST_IDLE);
  assign go      = start || rc_fire;

  assign to_load = ((state == ST_IDLE) && go) ||
                   ((state == ST_ID_WAIT) && avm_readdatavalid);
  assign rc_load = (state == ST_CHECK) || abort || ((state == ST_IDLE) && start);

  sysid_rd_timer #(.W(16)) u_to_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (to_load),
    .load_val (TO_LOAD),
    .dec      (in_req || in_wait),
    .expired  (to_exp)
  );

  sysid_rd_timer #(.W(32)) u_rc_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (rc_load),
    .load_val (RC_LOAD),
    .dec      (state == ST_IDLE),
    .expired  (rc_exp)
  );

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      rc_arm      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        avm_read    <= 1'b0;
        avm_address <= SYSID_ADDR_ID;
        timeout_err <= 1'b1;
        done        <= 1'b1;
        busy        <= 1'b0;
        rc_arm      <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (go) begin
            busy        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            state       <= ST_ID_REQ;
          end
          ST_ID_REQ: if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_ID_WAIT;
          end
          ST_ID_WAIT: if (rd_done) begin
            id_value    <= avm_readdata;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
            state       <= ST_TS_REQ;
          end
          ST_TS_REQ: if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_TS_WAIT;
          end
          ST_TS_WAIT: if (rd_done) begin
            ts_value <= avm_readdata;
            state    <= ST_CHECK;
          end
          ST_CHECK: begin
            id_ok       <= (id_value == EXP_ID);
            ts_ok       <= (ts_value == EXP_TS);
            done        <= 1'b1;
            busy        <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            rc_arm      <= 1'b1;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench: scoreboard of expected sequence results checked on done.
module tb_sysid_check_ctrl;

  localparam logic [31:0] TS_GOOD = 32'd1649580841;

  logic        clock = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT A: timeout 16, no recheck ----------------
  logic        start_a, a_addr, a_read, a_wait, a_rdv;
  logic [31:0] a_rdata;
  logic        a_busy, a_done, a_id_ok, a_ts_ok, a_to;
  logic [31:0] a_id, a_ts;

  sysid_check_ctrl #(.EXP_ID(32'd8), .EXP_TS(TS_GOOD), .TIMEOUT_CYC(16), .RECHECK_CYC(0)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wait),
    .avm_readdatavalid(a_rdv), .avm_readdata(a_rdata),
    .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .timeout_err(a_to), .id_value(a_id), .ts_value(a_ts)
  );

  // Slave A: stalls stall_n cycles per command, answers one cycle after accept
  int          stall_n = 0;
  int          stall_a = 0;
  int          acc_a = 0;
  bit          drop_ts = 1'b0;
  logic        inj_rdv = 1'b0;
  logic [31:0] id_word = 32'd8;
  logic [31:0] ts_word = TS_GOOD;
  logic        slv_rdv = 1'b0;
  logic [31:0] slv_data = '0;

  assign a_wait  = a_read && (stall_a < stall_n);
  assign a_rdv   = slv_rdv | inj_rdv;
  assign a_rdata = inj_rdv ? 32'hDEAD_BEEF : slv_data;

  always @(posedge clock) begin
    slv_rdv <= 1'b0;
    if (a_read && a_wait) stall_a <= stall_a + 1;
    if (a_read && !a_wait) begin
      stall_a <= 0;
      acc_a   <= acc_a + 1;
      if (!(a_addr && drop_ts)) begin
        slv_rdv  <= 1'b1;
        slv_data <= a_addr ? ts_word : id_word;
      end
    end
  end

  // ---------------- DUT B: recheck every 10 idle cycles ----------------
  logic        start_b, b_addr, b_read, b_wait, b_rdv;
  logic [31:0] b_rdata;
  logic        b_busy, b_done, b_id_ok, b_ts_ok, b_to;
  logic [31:0] b_id, b_ts;

  assign b_wait = 1'b0;
  always @(posedge clock) begin
    b_rdv   <= b_read;
    b_rdata <= b_addr ? TS_GOOD : 32'd8;
  end

  sysid_check_ctrl #(.EXP_ID(32'd8), .EXP_TS(TS_GOOD), .TIMEOUT_CYC(256), .RECHECK_CYC(10)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wait),
    .avm_readdatavalid(b_rdv), .avm_readdata(b_rdata),
    .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
    .timeout_err(b_to), .id_value(b_id), .ts_value(b_ts)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        id_ok, ts_ok, to;
    logic [31:0] idv, tsv;
    int          lat, start_cyc, acc_base, acc_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Score every done pulse against the oldest pending expectation
  always @(negedge clock) begin
    if (reset_n && a_done) begin
      if (sb.size() == 0) chk("spurious_done", sb.size(), 1);
      else begin
        mon_e = sb.pop_front();
        chk("latency",     cyc - mon_e.start_cyc, mon_e.lat);
        chk("id_ok",       a_id_ok, mon_e.id_ok);
        chk("ts_ok",       a_ts_ok, mon_e.ts_ok);
        chk("timeout_err", a_to,    mon_e.to);
        chk("id_value",    a_id,    mon_e.idv);
        chk("ts_value",    a_ts,    mon_e.tsv);
        chk("accepts",     acc_a - mon_e.acc_base, mon_e.acc_n);
        chk("busy_at_done", a_busy, 0);
        chk("read_at_done", a_read, 0);
      end
    end
  end

  // Address must not move while a stalled command is pending
  logic prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0;
  always @(negedge clock) begin
    if (reset_n && prev_read && prev_wait && a_read) chk("addr_stable", a_addr, prev_addr);
    prev_read = a_read;
    prev_wait = a_wait;
    prev_addr = a_addr;
  end

  task automatic launch_a(input logic iok, input logic tok, input logic to,
                          input logic [31:0] idv, input logic [31:0] tsv, input int lat);
    exp_t e;
    @(negedge clock);
    e.id_ok = iok; e.ts_ok = tok; e.to = to; e.idv = idv; e.tsv = tsv;
    e.lat = lat; e.start_cyc = cyc; e.acc_base = acc_a; e.acc_n = 2;
    sb.push_back(e);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    chk("drain", sb.size(), 0);
  endtask

  int t_done, t_busy;
  bit seen;

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_read", a_read, 0);  chk("rst_addr", a_addr, 0);
    chk("rst_busy", a_busy, 0);  chk("rst_done", a_done, 0);
    chk("rst_id_ok", a_id_ok, 0); chk("rst_ts_ok", a_ts_ok, 0);
    chk("rst_to", a_to, 0);      chk("rst_id", a_id, 0); chk("rst_ts", a_ts, 0);
    chk("rst_b_busy", b_busy, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_no_selfstart_b", b_busy, 0);

    // Zero-wait pass
    launch_a(1, 1, 0, 32'd8, TS_GOOD, 6);
    drain_a();

    // ID mismatch, then restore; a start while busy must not queue
    id_word = 32'd9;
    launch_a(0, 1, 0, 32'd9, TS_GOOD, 6);
    drain_a();
    chk("mismatch_held", a_id_ok, 0);
    id_word = 32'd8;
    launch_a(1, 1, 0, 32'd8, TS_GOOD, 6);
    start_a = 1'b1; @(negedge clock); start_a = 1'b0;
    drain_a();
    repeat (10) @(negedge clock);
    chk("no_queued_start", a_busy, 0);

    // Five-cycle waitrequest on each read
    stall_n = 5;
    launch_a(1, 1, 0, 32'd8, TS_GOOD, 16);
    drain_a();
    stall_n = 0;

    // Timestamp never answered: abort 16 cycles after TS_REQ entry
    drop_ts = 1'b1;
    launch_a(0, 0, 1, 32'd8, TS_GOOD, 19);
    drain_a();
    drop_ts = 1'b0;

    // Stray response in IDLE is ignored; status holds
    inj_rdv = 1'b1; @(negedge clock); inj_rdv = 1'b0;
    repeat (2) @(negedge clock);
    chk("stray_id", a_id, 32'd8);
    chk("stray_ts", a_ts, TS_GOOD);
    chk("stray_busy", a_busy, 0);
    chk("to_held", a_to, 1);

    // Reset while in TS_WAIT, then a late response
    drop_ts = 1'b1;
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    repeat (3) @(negedge clock);
    chk("in_ts_wait_busy", a_busy, 1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_mid_read", a_read, 0);
    reset_n = 1'b1;
    inj_rdv = 1'b1; @(negedge clock); inj_rdv = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_rst_busy", a_busy, 0); chk("post_rst_read", a_read, 0);
    chk("post_rst_id", a_id, 0);     chk("post_rst_ts", a_ts, 0);
    chk("post_rst_id_ok", a_id_ok, 0); chk("post_rst_to", a_to, 0);
    chk("post_rst_addr", a_addr, 0);
    drop_ts = 1'b0;

    // Recheck on DUT B
    @(negedge clock); start_b = 1'b1; t_busy = cyc;
    @(negedge clock); start_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (b_done) seen = 1; else @(negedge clock);
    end
    chk("b_first_done", seen, 1);
    t_done = cyc;
    chk("b_first_lat", t_done - t_busy, 6);
    chk("b_id_ok", b_id_ok, 1);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (b_busy) seen = 1; else @(negedge clock);
    end
    chk("b_recheck_seen", seen, 1);
    t_busy = cyc;
    chk("b_recheck_gap", t_busy - t_done, 10);
    start_b = 1'b1; @(negedge clock); start_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (b_done) seen = 1; else @(negedge clock);
    end
    chk("b_second_done", seen, 1);
    t_done = cyc;
    chk("b_second_lat", t_done - t_busy, 5);
    @(negedge clock);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (b_busy) seen = 1; else @(negedge clock);
    end
    chk("b_third_seen", seen, 1);
    chk("b_third_gap", cyc - t_done, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Avalon-MM read master that sequences the system-ID slave.
- Reads word 0 (ID) and word 1 (timestamp), then compares both against build-time expected values.
- Reports match / mismatch / timeout status to boot and health-monitor logic.
- Optionally re-runs the check periodically so a mismatched or reprogrammed image is flagged at run time.

Parameters:
- EXP_ID, 32'd8, expected value of ID word (address 0)
- EXP_TS, 32'd1649580841, expected value of timestamp word (address 1)
- TIMEOUT_CYC, 256, max cycles per read (request + response) before abort; legal range 2..65535
- RECHECK_CYC, 0, idle cycles between automatic re-checks; 0 disables auto re-check

Ports:
- clock  in  1  single system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  request one check sequence; level or pulse, sampled in IDLE only
- avm_address  out  1  word select: 0 = ID, 1 = timestamp
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; command accepted when avm_read=1 and avm_waitrequest=0
- avm_readdatavalid  in  1  response strobe
- avm_readdata  in  32  response data
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at end of every sequence (pass, fail or timeout)
- id_ok  out  1  captured ID equals EXP_ID
- ts_ok  out  1  captured timestamp equals EXP_TS
- timeout_err  out  1  last sequence aborted on timeout
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

Behaviour:
- Reset (clock edge with reset_n=0):
  - state=IDLE.
  - All outputs 0 (avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err, id_value, ts_value).
  - Timeout and recheck counters cleared.
  - Reset mid-read drops avm_read on the next edge; any later readdatavalid is ignored.
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK.
- IDLE:
  - start=1 (or recheck counter expired) -> ID_REQ.
  - On entry to ID_REQ: busy=1; id_ok, ts_ok and timeout_err cleared.
- ID_REQ:
  - avm_read=1, avm_address=0.
  - Held until avm_waitrequest=0, then -> ID_WAIT; avm_read drops on the following cycle.
- ID_WAIT:
  - avm_read=0.
  - On avm_readdatavalid=1: capture id_value, -> TS_REQ.
  - readdatavalid is not sampled in REQ states; earliest legal response is the cycle after acceptance.
- TS_REQ / TS_WAIT: identical to ID_REQ / ID_WAIT with avm_address=1; capture ts_value; -> CHECK.
- CHECK (one cycle):
  - id_ok <= (id_value==EXP_ID); ts_ok <= (ts_value==EXP_TS).
  - done=1, busy=0 on the same edge; -> IDLE.
  - Total minimum latency with zero-wait slave: start to done = 6 cycles.
- Timeout:
  - Counter cleared on entry to each REQ state; increments every cycle in REQ or WAIT.
  - When count reaches TIMEOUT_CYC-1 without completion: avm_read=0, timeout_err=1, done=1, busy=0, -> IDLE.
  - id_ok and ts_ok stay 0.
  - Captured values of completed reads remain visible.
- Recheck:
  - If RECHECK_CYC>0, counter loads RECHECK_CYC on every return to IDLE and decrements in IDLE; reaching 0 self-starts.
  - An external start in IDLE wins and reloads the counter.
- Input handling:
  - start while busy is ignored; no queuing.
  - Stray readdatavalid in IDLE, REQ or CHECK is ignored.
- Status outputs id_ok, ts_ok and timeout_err hold until the next sequence starts.
- Only one outstanding read at any time; avm_address is stable while avm_read=1.

Decomposition:
- Shared package sysid_pkg:
  - state enum.
  - Word-index constants SYSID_ADDR_ID=0, SYSID_ADDR_TS=1.
  - Status-bit positions for CSR mirroring.
- One natural sub-module, sysid_rd_timer: loadable down-counter with expire flag, instantiated twice (timeout, recheck).

Test Plan:
- Zero-wait slave returning 8 / 1649580841, start pulse -> done at cycle 6; id_ok=1, ts_ok=1, timeout_err=0, id_value=8.
- Slave returns ID=9 -> done; id_ok=0, ts_ok=1, id_value=9; a second start with ID=8 restores id_ok=1.
- waitrequest held 5 cycles on each read -> avm_read and address stable throughout; done at cycle 16; no duplicate acceptance.
- TIMEOUT_CYC=16, slave never asserts readdatavalid on timestamp read -> done 16 cycles after TS_REQ entry; timeout_err=1, ts_ok=0, avm_read=0.
- reset_n low during TS_WAIT, late readdatavalid after release -> all outputs 0, state IDLE, no capture.
- RECHECK_CYC=10, no start after first pass -> second sequence begins 10 cycles after first done; start pulse while busy has no effect.
